// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter among four byte sources
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req_valid[3:0]  per-requester byte-available flags
//   req_data[31:0]  requester i byte on bits [8i+7:8i]
//   req_ack[3:0]    one-cycle capture acknowledge to the granted requester
//   pause           blocks new grants; a frame in flight still completes
//   tx_data[7:0]    byte for the transmitter, stable for the whole frame
//   tx_ready        START_PULSE-cycle start pulse to the transmitter
//   grant_id[1:0]   requester currently or last served
//   busy            high while a frame is being timed (START or WAIT)
module uart_tx_arbiter #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FRAME_BITS  = 10,
    parameter int GAP_CYCLES  = 2,
    parameter int START_PULSE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ack,
    input  logic        pause,
    output logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic [1:0]  grant_id,
    output logic        busy
);

    localparam int BIT_CYCLES   = CLK_FREQ / BAUD;
    localparam int FRAME_CYCLES = BIT_CYCLES * FRAME_BITS + GAP_CYCLES;
    localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(START_PULSE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic [1:0]       rr_ptr;

    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;

    // Search from rr_ptr upward; the 2-bit add supplies the 3->0 wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            rr_ptr    <= '0;
            req_ack   <= '0;
            tx_data   <= 8'h00;
            tx_ready  <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            req_ack <= '0;
            case (state)
                IDLE: begin
                    tx_ready <= 1'b0;
                    if (!pause && found) begin
                        tx_data   <= req_data[{winner, 3'b000} +: 8];
                        grant_id  <= winner;
                        req_ack   <= 4'b0001 << winner;
                        tx_ready  <= 1'b1;
                        busy      <= 1'b1;
                        frame_cnt <= '0;
                        state     <= START;
                    end
                end
                START, WAIT: begin
                    // The frame-end check wins so a pulse as long as the
                    // whole frame still returns straight to IDLE.
                    if (frame_cnt == CNT_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b0;
                        rr_ptr   <= grant_id + 2'd1;
                    end else begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        if (state == START && frame_cnt == PULSE_LAST) begin
                            state    <= WAIT;
                            tx_ready <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int FRAME = 4342;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        pause;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .pause     (pause),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Grant log and protocol observations, sampled on the falling edge.
    int         cyc = 0;
    int         n_got = 0;
    logic [3:0] g_ack [64];
    logic [1:0] g_id  [64];
    logic [7:0] g_data[64];
    int         g_cyc [64];
    int         ack_viol = 0;
    int         data_viol = 0;
    int         busy_start = 0, busy_len = 0;
    int         ready_start = 0, ready_len = 0;
    logic       prev_busy = 1'b0, prev_ready = 1'b0;
    logic [3:0] prev_ack = 4'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (req_ack !== 4'b0000) begin
            if (prev_ack !== 4'b0000) ack_viol = ack_viol + 1;
            if (n_got < 64) begin
                g_ack[n_got]  = req_ack;
                g_id[n_got]   = grant_id;
                g_data[n_got] = tx_data;
                g_cyc[n_got]  = cyc;
                n_got = n_got + 1;
            end
        end
        if (busy && !prev_busy) busy_start = cyc;
        if (!busy && prev_busy) busy_len = cyc - busy_start;
        if (tx_ready && !prev_ready) ready_start = cyc;
        if (!tx_ready && prev_ready) ready_len = cyc - ready_start;
        if (busy && prev_busy && tx_data !== prev_data) data_viol = data_viol + 1;
        prev_busy  = busy;
        prev_ready = tx_ready;
        prev_ack   = req_ack;
        prev_data  = tx_data;
    end

    int base, av0, dv0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0;
        pause = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        base = n_got;
        av0 = ack_viol;
        dv0 = data_viol;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (n_got - base < n && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if (n_got - base < n) begin
            miscompares++;
            $display("FAIL wait_grants: got %0d grants, required %0d", n_got - base, n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pause = 1'b0;
        req_valid = 4'hF;
        req_data = 32'hDEADBEEF;
        tick();
        tick();
        vectors += 5;
        if (req_ack !== 4'b0) begin miscompares++; $display("FAIL reset_ack: got %b, required 0000", req_ack); end
        if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h, required 00", tx_data); end
        if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, required 0", tx_ready); end
        if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        req_data = 32'h0000_00A5;
        req_valid = 4'b0001;
        tick();
        vectors += 4;
        if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL single_ack: got %b, required 0001", req_ack); end
        if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b, required 1", tx_ready); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b, required 1", busy); end
        if (tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h, required a5", tx_data); end
        req_valid = 4'b0;
        tick();
        vectors += 2;
        if (req_ack !== 4'b0) begin miscompares++; $display("FAIL single_ack_drop: got %b, required 0000", req_ack); end
        if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready2: got %b, required 1", tx_ready); end
        wait_idle(FRAME + 10);
        vectors += 5;
        if (busy_len != FRAME) begin miscompares++; $display("FAIL single_busy_len: got %0d, required %0d", busy_len, FRAME); end
        if (ready_len != 2) begin miscompares++; $display("FAIL single_ready_len: got %0d, required 2", ready_len); end
        if (n_got - base != 1) begin miscompares++; $display("FAIL single_grants: got %0d, required 1", n_got - base); end
        if (ack_viol != av0) begin miscompares++; $display("FAIL single_ack_width: got %0d long acks, required 0", ack_viol - av0); end
        if (data_viol != dv0) begin miscompares++; $display("FAIL single_data_stable: got %0d changes, required 0", data_viol - dv0); end
    endtask

    task automatic test_all_four();
        logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        req_data = 32'h4433_2211;
        req_valid = 4'hF;
        wait_grants(5, 5 * (FRAME + 1) + 20);
        req_valid = 4'b0;
        for (int i = 0; i < 5; i++) begin
            vectors += 3;
            if (g_id[base + i] !== 2'(i % 4)) begin miscompares++; $display("FAIL four_id[%0d]: got %0d, required %0d", i, g_id[base + i], i % 4); end
            if (g_data[base + i] !== exp_data[i % 4]) begin miscompares++; $display("FAIL four_data[%0d]: got %h, required %h", i, g_data[base + i], exp_data[i % 4]); end
            if (g_ack[base + i] !== 4'(1 << (i % 4))) begin miscompares++; $display("FAIL four_ack[%0d]: got %b, required %b", i, g_ack[base + i], 4'(1 << (i % 4))); end
        end
        for (int i = 1; i < 5; i++) begin
            vectors++;
            if (g_cyc[base + i] - g_cyc[base + i - 1] != FRAME + 1) begin
                miscompares++;
                $display("FAIL four_gap[%0d]: got %0d, required %0d", i, g_cyc[base + i] - g_cyc[base + i - 1], FRAME + 1);
            end
        end
    endtask

    task automatic test_competing();
        logic [1:0] exp_id [4] = '{2'd2, 2'd3, 2'd2, 2'd3};
        do_reset();
        req_data = 32'h3B2A_0000;
        req_valid = 4'b0100;
        wait_grants(1, 20);
        req_valid = 4'b1100;
        wait_grants(4, 4 * (FRAME + 1) + 20);
        req_valid = 4'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (g_id[base + i] !== exp_id[i]) begin miscompares++; $display("FAIL compete_id[%0d]: got %0d, required %0d", i, g_id[base + i], exp_id[i]); end
        end
        vectors++;
        if (g_data[base + 1] !== 8'h3B) begin miscompares++; $display("FAIL compete_data: got %h, required 3b", g_data[base + 1]); end
    endtask

    task automatic test_pause();
        do_reset();
        req_data = 32'h0000_B7A1;
        req_valid = 4'b0001;
        wait_grants(1, 20);
        req_valid = 4'b0;
        repeat (100) tick();
        pause = 1'b1;
        req_valid = 4'b0010;
        wait_idle(FRAME + 10);
        vectors++;
        if (busy_len != FRAME) begin miscompares++; $display("FAIL pause_frame_len: got %0d, required %0d", busy_len, FRAME); end
        repeat (300) tick();
        vectors += 2;
        if (n_got - base != 1) begin miscompares++; $display("FAIL pause_hold: got %0d grants, required 1", n_got - base); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL pause_busy: got %b, required 0", busy); end
        pause = 1'b0;
        tick();
        req_valid = 4'b0;
        vectors += 3;
        if (req_ack !== 4'b0010) begin miscompares++; $display("FAIL pause_release_ack: got %b, required 0010", req_ack); end
        if (grant_id !== 2'd1) begin miscompares++; $display("FAIL pause_release_id: got %0d, required 1", grant_id); end
        if (tx_data !== 8'hB7) begin miscompares++; $display("FAIL pause_release_data: got %h, required b7", tx_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = 32'h00C5_0201;
        req_valid = 4'b0001;
        wait_grants(1, 20);
        req_valid = 4'b0;
        wait_idle(FRAME + 10);
        req_valid = 4'b0100;
        wait_grants(2, 20);
        req_valid = 4'b0;
        repeat (1000) tick();
        rst = 1'b1;
        tick();
        vectors += 5;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b, required 0", tx_ready); end
        if (tx_data !== 8'h00) begin miscompares++; $display("FAIL midrst_data: got %h, required 00", tx_data); end
        if (grant_id !== 2'd0) begin miscompares++; $display("FAIL midrst_grant: got %0d, required 0", grant_id); end
        if (req_ack !== 4'b0) begin miscompares++; $display("FAIL midrst_ack: got %b, required 0000", req_ack); end
        rst = 1'b0;
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0;
        vectors += 3;
        if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL midrst_first_ack: got %b, required 0001", req_ack); end
        if (grant_id !== 2'd0) begin miscompares++; $display("FAIL midrst_first_id: got %0d, required 0", grant_id); end
        if (tx_data !== 8'h01) begin miscompares++; $display("FAIL midrst_first_data: got %h, required 01", tx_data); end
    endtask

    task automatic test_valid_held();
        do_reset();
        req_data = 32'h0000_005E;
        req_valid = 4'b0001;
        wait_grants(2, 2 * (FRAME + 1) + 20);
        req_valid = 4'b0;
        vectors += 4;
        if (g_cyc[base + 1] - g_cyc[base] != FRAME + 1) begin
            miscompares++;
            $display("FAIL held_gap: got %0d, required %0d", g_cyc[base + 1] - g_cyc[base], FRAME + 1);
        end
        if (g_id[base + 1] !== 2'd0) begin miscompares++; $display("FAIL held_id: got %0d, required 0", g_id[base + 1]); end
        if (g_data[base + 1] !== 8'h5E) begin miscompares++; $display("FAIL held_data: got %h, required 5e", g_data[base + 1]); end
        if (ack_viol != av0) begin miscompares++; $display("FAIL held_ack_width: got %0d long acks, required 0", ack_viol - av0); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b0;
        req_data = 32'h0;
        pause = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_competing();
        test_pause();
        test_reset_mid();
        test_valid_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
